// File: rtl/rsa_keyparam_gen.sv
// rsa_keyparam_gen: RSA key-parameter generator.
// Draws primes p and q from a small prime ROM. The ROM index comes from a
// seedable Galois LFSR. A draw with p == q is redrawn. The generator then
// forms n = p*q and totient = (p-1)*(q-1) with a shift-add multiplier.
// It draws e from the same ROM until gcd(e, totient) == 1 and e < totient.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   seed_load, seed     load the LFSR; a zero seed selects 16'hACE1
//   start               request one key set (taken in IDLE or FAIL)
//   busy                a key set is being computed
//   valid, ready        result handshake; valid is held until ready
//   error               retry budget exhausted; held until the next start
//   p, q, e, n, totient results; updated only on entry to DONE
// The ROM image is the parameter vector ROM_INIT. Entry i sits at
// ROM_INIT[i*PW +: PW].
module rsa_keyparam_gen #(
  parameter int PW        = 12,
  parameter int DEPTH     = 8,
  parameter int LFSR_W    = 16,
  parameter int MAX_RETRY = 15,
  parameter logic [DEPTH*PW-1:0] ROM_INIT = {12'd31, 12'd37, 12'd41, 12'd43,
                                             12'd47, 12'd59, 12'd53, 12'd61}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                seed_load,
  input  logic [LFSR_W-1:0]   seed,
  input  logic                start,
  output logic                busy,
  output logic                valid,
  input  logic                ready,
  output logic                error,
  output logic [PW-1:0]       p,
  output logic [PW-1:0]       q,
  output logic [2*PW-1:0]     e,
  output logic [2*PW-1:0]     n,
  output logic [2*PW-1:0]     totient
);
  localparam int NW    = 2 * PW;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int RC_W  = $clog2(MAX_RETRY + 1);
  localparam int CNT_W = $clog2(PW) + 1;

  // Galois right-shift masks of maximal-length polynomials (bit k = tap k+1).
  function automatic logic [LFSR_W-1:0] lfsr_taps();
    logic [31:0] t;
    case (LFSR_W)
      2:  t = 32'h3;       3:  t = 32'h6;       4:  t = 32'hC;
      5:  t = 32'h14;      6:  t = 32'h30;      7:  t = 32'h60;
      8:  t = 32'hB8;      9:  t = 32'h110;     10: t = 32'h240;
      11: t = 32'h500;     12: t = 32'h829;     13: t = 32'h100D;
      14: t = 32'h2015;    15: t = 32'h6000;    24: t = 32'hE10000;
      32: t = 32'h80200003;
      default: t = 32'hB400;
    endcase
    return LFSR_W'(t);
  endfunction

  function automatic logic [PW-1:0] rom_word(input logic [IDX_W-1:0] idx);
    return ROM_INIT[idx*PW +: PW];
  endfunction

  localparam logic [LFSR_W-1:0] TAPS     = lfsr_taps();
  localparam logic [LFSR_W-1:0] SEED_DEF = LFSR_W'(16'hACE1);

  typedef enum logic [3:0] {
    IDLE, DRAW_P, DRAW_Q, CHK_PQ, MUL_N, MUL_T, DRAW_E, GCD, DONE, FAIL
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [RC_W-1:0]   retry;
  logic [LFSR_W-1:0] lfsr;
  logic [PW-1:0]     rom_q, p_w, q_w, mplier;
  logic [NW-1:0]     acc, mcand, acc_add, e_w, n_w, tot_w, ga, gb;
  logic              twos;
  logic              last_mul, last_draw, gcd_end, gcd_pass, retry_last;
  logic              take, retry_inc, load_out;

  assign acc_add    = acc + (mplier[0] ? mcand : '0);
  assign last_mul   = (cnt == CNT_W'(PW - 1));
  assign last_draw  = (cnt == CNT_W'(1));
  assign gcd_end    = (ga == '0) || (gb == '0);
  // A shared factor of two rules out gcd == 1, so no power-of-two accumulator is needed.
  assign gcd_pass   = !twos && ((ga | gb) == NW'(1)) && (e_w < tot_w);
  assign retry_last = (retry == RC_W'(MAX_RETRY - 1));

  // Control state, retry budget, LFSR and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      retry   <= '0;
      lfsr    <= SEED_DEF;
      p       <= '0;
      q       <= '0;
      e       <= '0;
      n       <= '0;
      totient <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + CNT_W'(1);
      if (take)           retry <= '0;
      else if (retry_inc) retry <= retry + RC_W'(1);
      if (seed_load)      lfsr <= (seed == '0) ? SEED_DEF : seed;
      else                lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : '0);
      if (load_out) begin
        p       <= p_w;
        q       <= q_w;
        e       <= e_w;
        n       <= n_w;
        totient <= tot_w;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = DRAW_P;
      DRAW_P:  if (last_draw) state_n = DRAW_Q;
      DRAW_Q:  if (last_draw) state_n = CHK_PQ;
      CHK_PQ:  if (p_w == q_w) state_n = retry_last ? FAIL : DRAW_Q;
               else            state_n = MUL_N;
      MUL_N:   if (last_mul) state_n = MUL_T;
      MUL_T:   if (last_mul) state_n = DRAW_E;
      DRAW_E:  if (last_draw) state_n = GCD;
      GCD:     if (gcd_end) begin
                 if (gcd_pass) state_n = DONE;
                 else          state_n = retry_last ? FAIL : DRAW_E;
               end
      DONE:    if (ready) state_n = IDLE;
      FAIL:    if (start) state_n = DRAW_P;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = !(state inside {IDLE, DONE, FAIL});
    valid     = (state == DONE);
    error     = (state == FAIL);
    take      = start && (state == IDLE || state == FAIL);
    retry_inc = ((state == CHK_PQ) && (p_w == q_w)) ||
                ((state == GCD) && gcd_end && !gcd_pass);
    load_out  = (state == GCD) && gcd_end && gcd_pass;
  end

  // Working datapath: ROM read, multiplier, binary gcd (no reset needed)
  always_ff @(posedge clk) begin
    rom_q <= rom_word(lfsr[IDX_W-1:0]);
    case (state)
      DRAW_P: if (last_draw) p_w <= rom_q;
      DRAW_Q: if (last_draw) q_w <= rom_q;
      CHK_PQ: begin
        acc    <= '0;
        mcand  <= NW'(p_w);
        mplier <= q_w;
      end
      MUL_N, MUL_T: begin
        acc    <= acc_add;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (last_mul) begin
          if (state == MUL_N) begin
            n_w    <= acc_add;
            acc    <= '0;
            mcand  <= NW'(p_w - PW'(1));
            mplier <= q_w - PW'(1);
          end else begin
            tot_w  <= acc_add;
          end
        end
      end
      DRAW_E: if (last_draw) begin
        e_w  <= NW'(rom_q);
        ga   <= NW'(rom_q);
        gb   <= tot_w;
        twos <= 1'b0;
      end
      GCD: if (!gcd_end) begin
        if (!ga[0] && !gb[0]) begin
          ga   <= ga >> 1;
          gb   <= gb >> 1;
          twos <= 1'b1;
        end else if (!ga[0]) begin
          ga <= ga >> 1;
        end else if (!gb[0]) begin
          gb <= gb >> 1;
        end else if (ga >= gb) begin
          ga <= (ga - gb) >> 1;
        end else begin
          gb <= (gb - ga) >> 1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rsa_keyparam_gen.sv
// Bench for rsa_keyparam_gen. It drives three two-entry-ROM instances:
//   unit 0 ROM {61,53}, unit 1 ROM {3,7}, unit 2 ROM {61,61}.
module tb_rsa_keyparam_gen;
  localparam int PW = 12;
  localparam int NW = 24;
  localparam int LW = 16;
  localparam logic [3*2*PW-1:0] ROMS = {24'h03D03D, 24'h007003, 24'h03503D};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          seed_load [3];
  logic [LW-1:0] seed      [3];
  logic          start     [3];
  logic          ready     [3];
  logic          busy      [3];
  logic          valid     [3];
  logic          error     [3];
  logic [PW-1:0] p         [3];
  logic [PW-1:0] q         [3];
  logic [NW-1:0] e         [3];
  logic [NW-1:0] n         [3];
  logic [NW-1:0] tot       [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rsa_keyparam_gen #(
      .PW(PW), .DEPTH(2), .LFSR_W(LW), .MAX_RETRY(15),
      .ROM_INIT(ROMS[g*2*PW +: 2*PW])
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load[g]), .seed(seed[g]),
      .start(start[g]), .busy(busy[g]), .valid(valid[g]), .ready(ready[g]),
      .error(error[g]), .p(p[g]), .q(q[g]), .e(e[g]), .n(n[g]), .totient(tot[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start and count cycles until valid, with a bounded wait.
  task automatic run_key(input int u, output int lat);
    bit ok;
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
    lat = 1;
    ok = valid[u];
    while (!ok && lat < 300) begin
      tick();
      lat++;
      ok = valid[u];
    end
    check($sformatf("u%0d_valid_in_time", u), ok, 1);
  endtask

  task automatic accept(input int u);
    ready[u] = 1'b1;
    tick();
    ready[u] = 1'b0;
    check($sformatf("u%0d_valid_drops", u), valid[u], 0);
  endtask

  task automatic seeded_run(input logic [LW-1:0] s, output int lat,
                            output logic [PW-1:0] rp, output logic [PW-1:0] rq,
                            output logic [NW-1:0] re);
    seed[0] = s;
    seed_load[0] = 1'b1;
    tick();
    seed_load[0] = 1'b0;
    repeat (3) tick();
    run_key(0, lat);
    rp = p[0];
    rq = q[0];
    re = e[0];
    check("t6_n", n[0], 3233);
    check("t6_tot", tot[0], 3120);
    accept(0);
  endtask

  int lat, lat_a, lat_b, lat_c, lat_d, max_lat;
  bit saw_valid;
  logic [PW-1:0] sp, sq, pa, qa, pb, qb, pc, qc, pd, qd;
  logic [NW-1:0] se, ea, eb, ec, ed;

  initial begin
    for (int i = 0; i < 3; i++) begin
      seed_load[i] = 1'b0;
      seed[i] = '0;
      start[i] = 1'b0;
      ready[i] = 1'b0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid_u%0d", i), valid[i], 0);
      check($sformatf("rst_busy_u%0d", i), busy[i], 0);
      check($sformatf("rst_error_u%0d", i), error[i], 0);
    end
    check("rst_pq", {p[0], q[0]}, 0);
    check("rst_e", e[0], 0);
    check("rst_n_out", n[0], 0);
    check("rst_tot", tot[0], 0);
    rst_n = 1'b1;
    tick();

    // T1: ROM {61,53}
    run_key(0, lat);
    check("t1_n", n[0], 3233);
    check("t1_tot", tot[0], 3120);
    check("t1_pq_set", (p[0] == 61 && q[0] == 53) || (p[0] == 53 && q[0] == 61), 1);
    check("t1_e", (e[0] == 61) || (e[0] == 53), 1);
    check("t1_busy", busy[0], 0);

    // T4: backpressure for 20 cycles, then accept
    sp = p[0];
    sq = q[0];
    se = e[0];
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t4_valid_held", valid[0], 1);
      check("t4_n_held", n[0], 3233);
      check("t4_tot_held", tot[0], 3120);
      check("t4_pqe_held", (p[0] == sp) && (q[0] == sq) && (e[0] == se), 1);
    end
    accept(0);
    check("t4_idle", busy[0], 0);
    check("t4_n_kept", n[0], 3233);

    // T2: ROM {3,7}; e=3 must be rejected; retries lengthen the run beyond 39 cycles
    max_lat = 0;
    for (int r = 0; r < 6; r++) begin
      repeat (r) tick();
      run_key(1, lat);
      check("t2_n", n[1], 21);
      check("t2_tot", tot[1], 12);
      check("t2_e", e[1], 7);
      check("t2_pq_sum", 32'(p[1]) + 32'(q[1]), 10);
      check("t2_min_lat", lat >= 39, 1);
      if (lat > max_lat) max_lat = lat;
      accept(1);
    end
    check("t2_retry_seen", max_lat > 39, 1);

    // T3: ROM all 61; 15 CHK_PQ rejections reach FAIL 48 cycles after start
    saw_valid = 1'b0;
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    lat = 1;
    while (!error[2] && lat < 200) begin
      if (valid[2]) saw_valid = 1'b1;
      tick();
      lat++;
    end
    check("t3_error", error[2], 1);
    check("t3_fail_lat", lat, 48);
    check("t3_no_valid", saw_valid, 0);
    check("t3_busy", busy[2], 0);
    ready[2] = 1'b1;
    tick();
    ready[2] = 1'b0;
    check("t3_error_held", error[2], 1);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    check("t3_error_clear", error[2], 0);
    check("t3_restart_busy", busy[2], 1);

    // T5: asynchronous reset in the middle of MUL_T
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (21) tick();
    check("t5_busy_before", busy[0], 1);
    check("t5_n_before", n[0], 3233);
    #2 rst_n = 1'b0;
    #1;
    check("t5_valid", valid[0], 0);
    check("t5_busy", busy[0], 0);
    check("t5_n", n[0], 0);
    check("t5_tot", tot[0], 0);
    check("t5_pq", {p[0], q[0]}, 0);
    check("t5_e", e[0], 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_key(0, lat);
    check("t5_post_n", n[0], 3233);
    check("t5_post_tot", tot[0], 3120);
    accept(0);

    // T6: seed 0 behaves as 16'hACE1; equal seeds give equal runs
    seeded_run(16'h0000, lat_a, pa, qa, ea);
    seeded_run(16'hACE1, lat_b, pb, qb, eb);
    seeded_run(16'h1234, lat_c, pc, qc, ec);
    seeded_run(16'h1234, lat_d, pd, qd, ed);
    check("t6_zero_lat", lat_a, lat_b);
    check("t6_zero_pq", {pa, qa}, {pb, qb});
    check("t6_zero_e", ea, eb);
    check("t6_same_lat", lat_c, lat_d);
    check("t6_same_pq", {pc, qc}, {pd, qd});
    check("t6_same_e", ec, ed);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "time limit");
  end

endmodule
